dht11_sensor_model: RTL and testbench

// - Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol.
// - Detects the host start pulse on the bus, then sends response + 40-bit frame
//   {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first, then releases the bus.
// - Used as on-board/bench stimulus for the DHT11 host receiver; drives open-drain (low or Z only).

---
 rtl/dht11_sensor_model.sv | 195 +++++++++++++++++++
 tb/tb_dht11_sensor_model.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dht11_sensor_model                                                          |
// | DHT11 responder: accepts a host start pulse, replies with a 40-bit frame.   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module dht11_sensor_model #(
  parameter int US_CYCLES      = 50,
  parameter int T_START_MIN_US = 18000,
  parameter int T_WAIT_US      = 30,
  parameter int T_RESP_LOW_US  = 80,
  parameter int T_RESP_HIGH_US = 80,
  parameter int T_BIT_LOW_US   = 50,
  parameter int T_BIT0_HIGH_US = 26,
  parameter int T_BIT1_HIGH_US = 70,
  parameter int T_EOT_LOW_US   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  inout  wire        bitComunDHT11,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       inject_bad_chk,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  localparam int CNT_W = $clog2(T_START_MIN_US * US_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_start_last = CNT_W'(T_START_MIN_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_wait_last  = CNT_W'(T_WAIT_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rlow_last  = CNT_W'(T_RESP_LOW_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rhigh_last = CNT_W'(T_RESP_HIGH_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_blow_last  = CNT_W'(T_BIT_LOW_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_b0_last    = CNT_W'(T_BIT0_HIGH_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_b1_last    = CNT_W'(T_BIT1_HIGH_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_eot_last   = CNT_W'(T_EOT_LOW_US * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_guard      = CNT_W'(4);

  typedef enum logic [3:0] {
    S_IDLE, S_HOST_LOW, S_WAIT_REL, S_RESP_WAIT, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_EOT_LOW
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [39:0]      r_shreg;
  logic [5:0]       r_bit_cnt;
  logic             r_sync1, r_line_s, r_armed;
  logic             r_pull_low, r_busy, r_done, r_abort;

  logic [7:0]       w_chk;
  logic [CNT_W-1:0] w_last;
  logic             w_contend;

  assign w_chk     = (hum_int + hum_dec + tmp_int + tmp_dec) ^ {8{inject_bad_chk}};
  // Our own release takes a few cycles to reach line_s; ignore lows before that.
  assign w_contend = (r_cnt >= c_guard) && !r_line_s;

  always_comb begin
    w_last = '0;
    case (r_state)
      S_RESP_WAIT: w_last = c_wait_last;
      S_RESP_LOW:  w_last = c_rlow_last;
      S_RESP_HIGH: w_last = c_rhigh_last;
      S_BIT_LOW:   w_last = c_blow_last;
      S_BIT_HIGH:  w_last = r_shreg[39] ? c_b1_last : c_b0_last;
      S_EOT_LOW:   w_last = c_eot_last;
      default:     w_last = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_line_s   <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_armed    <= 1'b0;
      r_pull_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_sync1  <= bitComunDHT11;
      r_line_s <= r_sync1;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      if (!en) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_pull_low <= 1'b0;
        r_busy     <= 1'b0;
        r_armed    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt      <= '0;
            r_pull_low <= 1'b0;
            // A low already in progress on entry must not start a count.
            if (!r_armed)
              r_armed <= r_line_s;
            else if (!r_line_s)
              r_state <= S_HOST_LOW;
          end
          S_HOST_LOW: begin
            if (r_line_s) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_start_last) begin
              r_state <= S_WAIT_REL;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WAIT_REL: begin
            if (r_line_s) begin
              r_shreg   <= {hum_int, hum_dec, tmp_int, tmp_dec, w_chk};
              r_bit_cnt <= 6'd39;
              r_state   <= S_RESP_WAIT;
              r_cnt     <= '0;
            end
          end
          S_RESP_WAIT, S_RESP_HIGH, S_BIT_HIGH: begin
            if (w_contend) begin
              r_abort    <= 1'b1;
              r_pull_low <= 1'b0;
              r_busy     <= 1'b0;
              r_armed    <= 1'b0;
              r_state    <= S_IDLE;
              r_cnt      <= '0;
            end else if (r_cnt == w_last) begin
              r_cnt      <= '0;
              r_pull_low <= 1'b1;
              if (r_state == S_RESP_WAIT) begin
                r_state <= S_RESP_LOW;
              end else if (r_state == S_RESP_HIGH) begin
                r_state <= S_BIT_LOW;
              end else begin
                r_shreg <= {r_shreg[38:0], 1'b0};
                if (r_bit_cnt == 6'd0) begin
                  r_state <= S_EOT_LOW;
                end else begin
                  r_bit_cnt <= r_bit_cnt - 6'd1;
                  r_state   <= S_BIT_LOW;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RESP_LOW, S_BIT_LOW, S_EOT_LOW: begin
            if (r_cnt == w_last) begin
              r_cnt      <= '0;
              r_pull_low <= 1'b0;
              if (r_state == S_RESP_LOW) begin
                r_state <= S_RESP_HIGH;
              end else if (r_state == S_BIT_LOW) begin
                r_state <= S_BIT_HIGH;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_armed <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pull_low <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bitComunDHT11 = r_pull_low ? 1'b0 : 1'bz;
  assign busy          = r_busy;
  assign done          = r_done;
  assign abort         = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_dht11_sensor_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dht11_sensor_model                                                       |
// | Drives host start pulses and checks the emulated DHT11 bus waveform.        |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_dht11_sensor_model;

  // One clock per microsecond keeps a full frame to a few thousand cycles.
  localparam int US = 1, TSTART = 400;
  localparam int TW = 30, TRL = 80, TRH = 80, TBL = 50, TB0 = 26, TB1 = 70, TEOT = 50;

  logic       clk = 1'b0, reset = 1'b1, en = 1'b1, host_low = 1'b0, bad = 1'b0;
  logic [7:0] hi = '0, hd = '0, ti = '0, td = '0;
  logic       busy, done, abort;
  wire        bus;

  pullup (bus);
  assign bus = host_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dht11_sensor_model #(.US_CYCLES(US), .T_START_MIN_US(TSTART)) dut (
    .clk(clk), .reset(reset), .en(en), .bitComunDHT11(bus),
    .hum_int(hi), .hum_dec(hd), .tmp_int(ti), .tmp_dec(td),
    .inject_bad_chk(bad), .busy(busy), .done(done), .abort(abort)
  );

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the expected bus as (level, length) segments counted from the first
  // clock edge after the host releases the line.
  int seg_len[$];
  bit seg_lvl[$];
  int total = 0, rel_cyc = 0;
  bit model_on = 1'b0;

  function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d, input bit inj);
    int s;
    logic [7:0] chk;
    s   = int'(a) + int'(b) + int'(c) + int'(d);
    chk = 8'(s % 256);
    if (inj) chk = 8'(255 - int'(chk));
    return {a, b, c, d, chk};
  endfunction

  task automatic build_model(input logic [39:0] f);
    seg_len.delete(); seg_lvl.delete();
    seg_len.push_back(TW + 2); seg_lvl.push_back(1'b1);
    seg_len.push_back(TRL);    seg_lvl.push_back(1'b0);
    seg_len.push_back(TRH);    seg_lvl.push_back(1'b1);
    for (int i = 39; i >= 0; i--) begin
      seg_len.push_back(TBL);              seg_lvl.push_back(1'b0);
      seg_len.push_back(f[i] ? TB1 : TB0); seg_lvl.push_back(1'b1);
    end
    seg_len.push_back(TEOT); seg_lvl.push_back(1'b0);
    total = 0;
    foreach (seg_len[i]) total += seg_len[i];
  endtask

  function automatic bit level_at(input int k);
    int acc = 0;
    foreach (seg_len[i]) begin
      if (k < acc + seg_len[i]) return seg_lvl[i];
      acc += seg_len[i];
    end
    return 1'b1;
  endfunction

  function automatic int seg_start(input int idx);
    int acc = 0;
    for (int i = 0; i < idx; i++) acc += seg_len[i];
    return acc;
  endfunction

  task automatic compare_loop();
    int k;
    logic [3:0] exp_v;
    forever begin
      @(negedge clk);
      if (model_on) begin
        k = cyc - rel_cyc;
        if (k >= 0 && k <= total) begin
          exp_v = {(k < total) ? level_at(k) : 1'b1, k < total, k == total, 1'b0};
          check("frame{bus,busy,done,abort}", {bus, busy, done, abort}, exp_v);
        end
      end
    end
  endtask

  task automatic wait_k(input int t);
    do @(negedge clk); while (cyc - rel_cyc < t);
  endtask

  task automatic setup_frame(input logic [7:0] a, b, c, d, input bit inj);
    hi = a; hd = b; ti = c; td = d; bad = inj;
    build_model(model_frame(a, b, c, d, inj));
    @(posedge clk); #1 host_low = 1'b1;
    repeat (TSTART + 20) @(posedge clk);
    #1 check("accept_busy", busy, 1'b1);
    host_low = 1'b0;
    rel_cyc  = cyc + 1;
    model_on = 1'b1;
  endtask

  task automatic full_frame(input logic [7:0] a, b, c, d, input bit inj,
                            input logic [39:0] lit, input bit change_mid, input string nm);
    int runs[$];
    int run = 0, dn = 0;
    logic [39:0] dec = '0;
    check({nm, "_model"}, model_frame(a, b, c, d, inj), lit);
    setup_frame(a, b, c, d, inj);
    do begin
      @(negedge clk);
      if (change_mid && (cyc - rel_cyc) == 100) hi = 8'h50;
      if (bus === 1'b1) run++;
      else begin
        if (run > 0) runs.push_back(run);
        run = 0;
      end
      if (done) dn++;
    end while (cyc - rel_cyc <= total + 5);
    model_on = 1'b0;
    check({nm, "_highruns"}, runs.size(), 42);
    if (runs.size() >= 42)
      for (int j = 0; j < 40; j++) dec = {dec[38:0], runs[2+j] > 48};
    check({nm, "_decode"}, dec, lit);
    check({nm, "_done_pulses"}, dn, 1);
    check({nm, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic short_start(input int len, input string nm);
    int bsy = 0, lows = 0;
    @(posedge clk); #1 host_low = 1'b1;
    repeat (len) begin
      @(negedge clk);
      if (busy) bsy++;
    end
    @(posedge clk); #1 host_low = 1'b0;
    repeat (TSTART + 50) begin
      @(negedge clk);
      if (busy) bsy++;
      if (bus !== 1'b1) lows++;
    end
    check({nm, "_busy"}, bsy, 0);
    check({nm, "_drive"}, lows, 0);
  endtask

  initial begin
    int bsy, lows, dn;
    fork compare_loop(); join_none

    repeat (3) @(negedge clk);
    check("reset_state{bus,busy,done,abort}", {bus, busy, done, abort}, 4'b1000);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // Nominal frame, checksum wrap and its inverted variant, mid-frame data change.
    full_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 40'h3700190555, 1'b0, "t1_nominal");
    repeat (10) @(posedge clk);
    short_start(100, "t2_short100");
    short_start(TSTART - 50, "t2_short_near");
    full_frame(8'hFF, 8'hFF, 8'h02, 8'h00, 1'b0, 40'hFFFF020000, 1'b0, "t3_wrap");
    repeat (10) @(posedge clk);
    full_frame(8'hFF, 8'hFF, 8'h02, 8'h00, 1'b1, 40'hFFFF0200FF, 1'b0, "t3_badchk");
    repeat (10) @(posedge clk);
    full_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 40'h3700190555, 1'b1, "t6_datachange");
    repeat (10) @(posedge clk);

    // Host grabs the line 10 cycles into the released phase of bit 20.
    setup_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    wait_k(seg_start(3 + 2*20 + 1) + 9);
    @(posedge clk); #1 model_on = 1'b0; host_low = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_pre{abort,busy}", {abort, busy}, 2'b01);
    end
    @(negedge clk);
    check("t4_abort{abort,busy,done}", {abort, busy, done}, 3'b100);
    @(negedge clk);
    check("t4_abort_single", abort, 1'b0);
    bsy = 0; dn = 0;
    repeat (TSTART + 50) begin
      @(negedge clk);
      if (busy) bsy++;
      if (done) dn++;
    end
    @(posedge clk); #1 host_low = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bsy++;
      if (bus !== 1'b1) lows++;
    end
    check("t4_no_restart_busy", bsy, 0);
    check("t4_no_done", dn, 0);
    check("t4_bus_released", lows, 0);

    // Asynchronous reset in the middle of the bit-5 low preamble.
    setup_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    wait_k(seg_start(3 + 2*5) + 20);
    check("t5_prelow_bus", bus, 1'b0);
    model_on = 1'b0;
    #2 reset = 1'b1;
    #1 check("t5_async{bus,busy,done,abort}", {bus, busy, done, abort}, 4'b1000);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // Enable drop in the middle of the bit-10 low preamble.
    setup_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    wait_k(seg_start(3 + 2*10) + 10);
    check("t5_en_prelow_bus", bus, 1'b0);
    @(posedge clk); #1 model_on = 1'b0; en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t5_en_off{bus,busy}", {bus, busy}, 2'b10);
    dn = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || abort) dn++;
    end
    check("t5_en_no_done", dn, 0);
    en = 1'b1;
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
